pingpong_ram_x18: RTL and testbench
===================================

# pingpong_ram_x18

Double-buffered (ping-pong) 18-bit RAM used inside each Monte-Carlo core to hold the exp(sigma) and exp(mu) lookup tables. One bank is read by the core's datapath while the host loads the next table into the other bank. The `switch` input swaps the two roles. Reads are registered with one-cycle latency, so a ROM or RAM address source lines up with other one-cycle pipeline stages.

## Interface
- `ADDR_WIDTH`, default 10: address width per bank. Depth is 2^ADDR_WIDTH words per bank (cores use 10 for the sigma table and 9 for the mu table).
- `CLK`  input  1: sole clock, rising edge.
- `RST`  input  1: synchronous, active-high reset.
- `WE`  input  1: write enable for the buffer bank.
- `switch`  input  1: bank role select.
- `readAddr`  input  ADDR_WIDTH: read address into the active bank.
- `writeAddr`  input  ADDR_WIDTH: write address into the buffer bank.
- `writeData`  input  18: write data.
- `readData`  output  18: registered read data.
- One clock; reset is synchronous and active-high (ports `CLK`, `RST`).

## Operation
- The block has two banks, bank0 and bank1, each 2^ADDR_WIDTH × 18 bits.
- `switch`=0: reads come from bank0 (active); writes go to bank1 (buffer).
- `switch`=1: reads come from bank1; writes go to bank0.
- Read and write always target opposite banks at the same edge, so no read/write collision is possible.
- There is no read enable. Every non-reset edge sets `readData` to the active bank's word at `readAddr`.
- Write: at an edge with `WE`=1 and `RST`=0, the buffer bank's word at `writeAddr` is set to `writeData`. If `WE`=0, nothing is written.
- Data is treated as an unsigned 18-bit word. The block does no arithmetic and no width conversion.
- Reset:
  - `readData` is set to 0.
  - Writes are suppressed while `RST`=1.
  - Memory contents are not cleared; they are retained through reset.
- Every address in 0 … 2^ADDR_WIDTH−1 is valid. There is no wrap or out-of-range case.

## Timing
- Read latency is 1 cycle. `readAddr` and `switch` are sampled at edge k, and the data appears on `readData` after edge k and holds until edge k+1.
- Write takes effect at the edge. A read of the same address in the same bank returns the new data no earlier than 1 cycle after a `switch` toggle makes that bank active.
- `switch` toggling at edge k:
  - The read at edge k uses the new active bank.
  - A write at edge k uses the new buffer bank.
- `RST` asserted mid-stream: `readData` is 0 on the next cycle. Normal reads resume at the first edge with `RST`=0.
- Only `readData` is an output; its reset value is 0.

## Configuration
- `PINGPONG_RAM_ZERO_INIT_EN`
  - Defined: both banks are initialised to all zeros at configuration / simulation start, so a read before any write returns 0.
  - Undefined: initial contents are unspecified (X in simulation). Only written locations may be relied on.

## Structure
- Shared package holds:
  - `RAM_DATA_W = 18`.
  - The bank-select convention constants `BANK_ACTIVE_SW0 = 0` and `BANK_ACTIVE_SW1 = 1`.
- One sub-module, `sdp_bank`: a simple dual-port (1 write, 1 synchronous read) 18-bit memory, instantiated twice.
- The top level does:
  - Per-bank write-enable steering: `WE & ~RST & (switch ? bank0 : bank1)`.
  - A registered read-data mux.

## Test plan
- **Reset.** Hold `RST`=1 for 2 cycles with `WE`=1 → `readData`=0 and no bank is written.
- **Load and switch.** With `switch`=0, write 0x12345 to address 5 and 0x3FFFF to address 1023, then set `switch`=1 and read addresses 5 and 1023 → 0x12345 and 0x3FFFF, each exactly 1 cycle after the address is applied.
- **Isolation.** With `switch`=0, write 0x00ABC to address 7 while reading address 7 → `readData` does not show 0x00ABC. After `switch`=1 and a read of address 7, it does.
- **Toggle edge.** Toggle `switch` at the same edge as a write with `WE`=1 → the write lands in the new buffer bank, and the read at that edge comes from the new active bank.
- **Back-to-back stream.** Read addresses 0…511 on consecutive cycles (ADDR_WIDTH=9) → the data sequence matches what was written, with a 1-cycle lag and no bubbles.
- **Zero init.** With `PINGPONG_RAM_ZERO_INIT_EN` defined, read unwritten address 100 → 0.

Source files
------------

// File: rtl/pingpong_ram_x18_pkg.sv
// Shared definitions for the ping-pong 18-bit lookup-table RAM.
// Optional build macro PINGPONG_RAM_ZERO_INIT_EN (used in the bank file) zero-fills both banks.
package pingpong_ram_x18_pkg;

    localparam int RAM_DATA_W = 18;

    // Value of `switch` that makes a given bank the active (read) bank.
    localparam logic BANK_ACTIVE_SW0 = 1'b0;
    localparam logic BANK_ACTIVE_SW1 = 1'b1;

    typedef logic [RAM_DATA_W-1:0] ram_word_t;

endpackage

// File: rtl/pingpong_ram_x18_if.sv
// Host/datapath bus of the ping-pong RAM; master drives, the RAM is the slave.
// Related build macro: PINGPONG_RAM_ZERO_INIT_EN (no effect on this interface).
interface pingpong_ram_x18_if
    import pingpong_ram_x18_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
);

    logic                  WE;
    logic                  switch;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [ADDR_WIDTH-1:0] writeAddr;
    ram_word_t             writeData;
    ram_word_t             readData;

    modport master (
        output WE, switch, readAddr, writeAddr, writeData,
        input  readData
    );

    modport slave (
        input  WE, switch, readAddr, writeAddr, writeData,
        output readData
    );

endinterface

// File: rtl/pingpong_ram_x18_sdp_bank.sv
// One simple dual-port bank: one write port, one synchronous read port, 18-bit words.
// Build macro PINGPONG_RAM_ZERO_INIT_EN: contents start as all zeros instead of unspecified.
module sdp_bank
    import pingpong_ram_x18_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  ram_word_t             wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output ram_word_t             rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef PINGPONG_RAM_ZERO_INIT_EN
    ram_word_t mem_q [DEPTH] = '{default: '0};
`else
    ram_word_t mem_q [DEPTH];
`endif

    ram_word_t rd_data_q;

    // NOTE: the array has no reset branch so it maps onto block RAM; a reset loop would force flops.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pingpong_ram_x18.sv
// Ping-pong 18-bit RAM: the datapath reads one bank while the host loads the other.
// Build macro PINGPONG_RAM_ZERO_INIT_EN zero-fills both banks at start-up.
module pingpong_ram_x18
    import pingpong_ram_x18_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic              CLK,
    input  logic              RST,
    pingpong_ram_x18_if.slave bus
);

    logic      bank0_we;
    logic      bank1_we;
    ram_word_t bank0_rd;
    ram_word_t bank1_rd;

    logic      rd_sel_d;
    logic      rd_sel_q;
    logic      rd_zero_d;
    logic      rd_zero_q;
    ram_word_t rd_mux;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        bank0_we  = 1'b0;
        bank1_we  = 1'b0;
        rd_sel_d  = bus.switch;
        rd_zero_d = RST;
        if (bus.WE && !RST) begin
            bank0_we = (bus.switch == BANK_ACTIVE_SW1);
            bank1_we = (bus.switch == BANK_ACTIVE_SW0);
        end
    end

    sdp_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .clk_i     (CLK),
        .wr_en_i   (bank0_we),
        .wr_addr_i (bus.writeAddr),
        .wr_data_i (bus.writeData),
        .rd_addr_i (bus.readAddr),
        .rd_data_o (bank0_rd)
    );

    sdp_bank #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .clk_i     (CLK),
        .wr_en_i   (bank1_we),
        .wr_addr_i (bus.writeAddr),
        .wr_data_i (bus.writeData),
        .rd_addr_i (bus.readAddr),
        .rd_data_o (bank1_rd)
    );

    // Select and blanking flags are captured on the same edge as the bank read registers.
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_zero_q <= 1'b1;
            rd_sel_q  <= BANK_ACTIVE_SW0;
        end else begin
            rd_zero_q <= rd_zero_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (!rd_zero_q) begin
            rd_mux = (rd_sel_q == BANK_ACTIVE_SW1) ? bank1_rd : bank0_rd;
        end
    end

    assign bus.readData = rd_mux;

endmodule

// File: tb/tb_pingpong_ram_x18.sv
// Randomized self-checking bench for pingpong_ram_x18 against a two-array reference model.
// Honours PINGPONG_RAM_ZERO_INIT_EN when the design is built with it.
module tb_pingpong_ram_x18;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;

    pingpong_ram_x18_if #(.ADDR_WIDTH(AW)) bus ();

    pingpong_ram_x18 #(.ADDR_WIDTH(AW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: bank contents plus a flag for words whose value is defined.
    logic [17:0] model_mem [2][DEPTH];
    bit          known     [2][DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare shortly after the edge.
    task automatic cycle(input bit r, input bit we, input bit sw,
                         input int ra, input int wa, input logic [17:0] wd,
                         input string tag);
        logic [17:0] exp_val;
        bit          exp_known;
        int          rd_bank;
        int          wr_bank;
        rst           = r;
        bus.WE        = we;
        bus.switch    = sw;
        bus.readAddr  = AW'(ra);
        bus.writeAddr = AW'(wa);
        bus.writeData = wd;
        @(posedge clk);
        rd_bank = sw ? 1 : 0;
        wr_bank = sw ? 0 : 1;
        if (r) begin
            exp_val   = '0;
            exp_known = 1'b1;
        end else begin
            exp_val   = model_mem[rd_bank][ra];
            exp_known = known[rd_bank][ra];
        end
        if (we && !r) begin
            model_mem[wr_bank][wa] = wd;
            known[wr_bank][wa]     = 1'b1;
        end
        #1;
        if (exp_known) check(tag, bus.readData, exp_val);
    endtask

    initial begin
        logic [17:0] stream_data;
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                model_mem[b][a] = '0;
`ifdef PINGPONG_RAM_ZERO_INIT_EN
                known[b][a] = 1'b1;
`else
                known[b][a] = 1'b0;
`endif
            end
        end

        // Power-up reset, then an unwritten read (defined only with zero init).
        cycle(1, 0, 0, 0, 0, 18'h0, "reset_init");
        cycle(1, 0, 0, 0, 0, 18'h0, "reset_init");
        cycle(0, 0, 0, 100, 0, 18'h0, "zero_init");

        // Reset with WE held high must not write either bank.
        cycle(0, 1, 0, 0, 3, 18'h11111, "pre_rst_wr");
        cycle(0, 1, 1, 0, 3, 18'h22222, "pre_rst_wr");
        cycle(1, 1, 0, 3, 3, 18'h2AAAA, "reset_we");
        cycle(1, 1, 1, 3, 3, 18'h2AAAA, "reset_we");
        cycle(0, 0, 1, 3, 0, 18'h0, "rst_no_wr_b1");
        cycle(0, 0, 0, 3, 0, 18'h0, "rst_no_wr_b0");
        check("rst_retained", bus.readData, 18'h22222);

        // Load and switch, including the top address.
        cycle(0, 1, 0, 0, 5, 18'h12345, "load");
        cycle(0, 1, 0, 0, 1023, 18'h3FFFF, "load");
        cycle(0, 0, 1, 5, 0, 18'h0, "switch_rd5");
        check("latency_rd5", bus.readData, 18'h12345);
        cycle(0, 0, 1, 1023, 0, 18'h0, "switch_rd1023");
        check("latency_rd1023", bus.readData, 18'h3FFFF);

        // Isolation: a write into the buffer bank is invisible at the same address in the active bank.
        cycle(0, 1, 1, 0, 7, 18'h00111, "iso_prep");
        cycle(0, 1, 0, 7, 7, 18'h00ABC, "iso_same_addr");
        cycle(0, 0, 0, 7, 0, 18'h0, "iso_after");
        cycle(0, 0, 1, 7, 0, 18'h0, "iso_switched");
        check("iso_visible", bus.readData, 18'h00ABC);

        // Toggle edge: switch flips together with a write and a read.
        cycle(0, 0, 0, 0, 0, 18'h0, "toggle_prep");
        cycle(0, 1, 1, 5, 9, 18'h0F0F0, "toggle_rd_new");
        check("toggle_active", bus.readData, 18'h12345);
        cycle(0, 0, 0, 9, 0, 18'h0, "toggle_wr_new");
        check("toggle_buffer", bus.readData, 18'h0F0F0);

        // Back-to-back stream over 0..511.
        for (int a = 0; a < 512; a++) begin
            stream_data = 18'($urandom);
            cycle(0, 1, 0, 0, a, stream_data, "stream_load");
        end
        for (int a = 0; a < 512; a++) begin
            cycle(0, 0, 1, a, 0, 18'h0, "stream_rd");
        end

        // Mid-stream reset then immediate resumption.
        cycle(1, 0, 1, 10, 0, 18'h0, "mid_rst");
        cycle(0, 0, 1, 10, 0, 18'h0, "mid_rst_resume");

        // Preload a small window in both banks, then random traffic.
        for (int a = 0; a < 32; a++) cycle(0, 1, 0, 0, a, 18'($urandom), "rnd_prep");
        for (int a = 0; a < 32; a++) cycle(0, 1, 1, 0, a, 18'($urandom), "rnd_prep");
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  18'($urandom), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
